eth_rx_frame_filter: RTL and testbench
======================================

Name: eth_rx_frame_filter

Overview:
- Downstream of the MII nibble-to-byte converter in the Ethernet receive path.
- Consumes its byte stream: post-SFD bytes, one `in_valid` strobe per byte, roughly every second clock.
- Detects frame end by an idle gap, filters on destination MAC (own or broadcast), checks FCS (CRC-32) and length, and strips dest MAC and FCS.
- Forwards the rest as a byte stream with start/end markers and per-frame status to the frame buffer writer.

Parameters:
- MAC_ADDR, 48'h02_00_00_00_00_01, station address; byte 0 is MSB [47:40], first on the wire.
- GAP_CYCLES, 4, consecutive clocks without `in_valid` that close a frame (must be ≥3).
- MIN_LEN, 64, minimum frame length in bytes, dest MAC through FCS inclusive.
- MAX_LEN, 1518, maximum frame length in bytes, same span.

Ports:
- clock  in  1  system clock (25 MHz)
- reset_n  in  1  asynchronous active-low reset
- in_data  in  8  received byte
- in_valid  in  1  byte strobe, one clock per byte
- in_error  in  1  converter misalignment flag; any high sample during frame or gap marks frame bad
- out_data  out  8  forwarded byte
- out_valid  out  1  out_data strobe
- out_sof  out  1  with out_valid on first forwarded byte (source MAC byte 0)
- out_eof  out  1  one-clock pulse closing a frame that produced out_sof
- out_good  out  1  with out_eof: frame passed all checks
- out_status  out  4  with out_eof: {conv_err, too_long, runt, crc_err}
- cnt_good  out  16  saturating count of good frames
- cnt_bad  out  16  saturating count of accepted-address frames closed bad
- cnt_dropped  out  16  saturating count of frames rejected by address filter

Behaviour:
- Reset: all outputs 0, counters 0, FSM IDLE, CRC register 32'hFFFFFFFF, delay line empty.
- FSM states:
  - IDLE: first `in_valid` starts a frame; byte index 0 goes to HDR.
  - HDR: compare bytes 0..5 against MAC_ADDR and 48'hFFFFFFFFFFFF. At byte 5, any match goes to PASS, otherwise DROP.
  - PASS: forward bytes.
  - DROP: absorb bytes, no output.
  - Frame close: gap counter reaches GAP_CYCLES. Go to IDLE the next clock.
- Gap counter: clears on every `in_valid` and counts otherwise while not IDLE. An `in_valid` before GAP_CYCLES continues the same frame.
- Byte counter: 11 bits, saturates at 2047, counts every byte including FCS.
- CRC:
  - Reflected CRC-32 (poly 0x04C11DB7), init all-ones, updated on every byte from index 0 through the last byte.
  - At close, good FCS ⇔ register == 32'hC704DD7B (residue, no final inversion).
- Output delay and FCS strip:
  - 4-byte shift line; byte k is emitted only when byte k+4 arrives, so the final 4 bytes (FCS) are never emitted.
  - Bytes with index ≥6 are emitted; out_valid occurs one clock after the `in_valid` of byte k+4.
  - out_sof accompanies byte 6.
- Too long: once byte count exceeds MAX_LEN, forwarding stops and too_long is set. out_eof is still issued.
- Status at close:
  - crc_err = residue mismatch
  - runt = count < MIN_LEN
  - too_long as above
  - conv_err = sticky in_error
  - out_good = none set
- PASS closing:
  - out_eof, out_good and out_status are driven one clock after the gap-counter terminal value.
  - Exactly one of cnt_good or cnt_bad increments in that same clock.
  - If no byte 6 was ever emitted (frame shorter than 11 bytes), out_eof is suppressed and only cnt_bad increments.
- DROP closing: cnt_dropped increments; no out_eof.
- Frame ending inside HDR (<6 bytes): counts as dropped.
- out_eof never coincides with out_valid, because the gap is ≥3 clocks.
- Reset mid-frame: immediate abort with no eof. Bytes after release start a new frame, normally closed bad.
- Counters hold at 16'hFFFF.

Decomposition:
- Package eth_rx_pkg:
  - CRC32_POLY, CRC32_INIT, CRC32_RESIDUE constants
  - BROADCAST_MAC
  - status bit index constants
  - FSM state enum {IDLE, HDR, PASS, DROP}
- Sub-module eth_crc32_d8: combinational 8-bit-per-step reflected CRC-32 next-state function; this block holds the register.

Test Plan:
- Unicast to MAC_ADDR, 64 bytes, valid FCS, bytes every 2 clocks, then idle → 54 out_valid bytes (source MAC onward), out_sof on first, out_eof with out_good=1, status 0, cnt_good=1.
- Broadcast dest, 100-byte valid frame → 90 bytes forwarded, out_good=1.
- Dest 02:00:00:00:00:02, valid FCS → no out_valid or out_eof, cnt_dropped=1.
- Valid 64-byte frame with payload byte 20 flipped → 54 bytes, out_eof, out_good=0, out_status=4'b0001, cnt_bad=1.
- 40-byte frame with correct FCS → out_status=4'b0010. Then a 1600-byte frame → forwarding stops after byte 1517, out_status[2]=1.
- in_error pulse 1 clock after the last byte of a valid frame → out_status=4'b1000.
- reset_n low for 1 clock at byte 30 → no eof. The following valid frame closes good, and counters restart from 0.
- `in_valid` gap of 3 clocks mid-frame (GAP_CYCLES=4) → frame not split, closes good.

Source files
------------

// File: rtl/eth_rx_pkg.sv
// Shared constants, status bit positions and FSM state type for the Ethernet
// receive frame filter.
package eth_rx_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;

  localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

  localparam int ST_CRC_ERR  = 0;
  localparam int ST_RUNT     = 1;
  localparam int ST_TOO_LONG = 2;
  localparam int ST_CONV_ERR = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PASS = 2'd2,
    DROP = 2'd3
  } state_t;

  // Byte idx of an address, byte 0 being the first one on the wire.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = mac[47:40];
      3'd1:    b = mac[39:32];
      3'd2:    b = mac[31:24];
      3'd3:    b = mac[23:16];
      3'd4:    b = mac[15:8];
      3'd5:    b = mac[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// One-byte step of the reflected CRC-32: data bits enter LSB first into an
// MSB-first register, so a good frame leaves the non-reflected residue.
module eth_crc32_d8
  import eth_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ data[i]) begin
        c = {c[30:0], 1'b0} ^ CRC32_POLY;
      end else begin
        c = {c[30:0], 1'b0};
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_rx_frame_filter.sv
// Receive frame filter: closes frames on an idle gap, filters on destination
// MAC, checks FCS and length, strips dest MAC and FCS, reports per-frame status.
module eth_rx_frame_filter
  import eth_rx_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR   = 48'h02_00_00_00_00_01,
  parameter int          GAP_CYCLES = 4,
  parameter int          MIN_LEN    = 64,
  parameter int          MAX_LEN    = 1518
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_error,
  output logic [7:0]   out_data,
  output logic         out_valid,
  output logic         out_sof,
  output logic         out_eof,
  output logic         out_good,
  output logic [3:0]   out_status,
  output logic [15:0]  cnt_good,
  output logic [15:0]  cnt_bad,
  output logic [15:0]  cnt_dropped,
  output state_t       dbg_state
);

  // Strobe protocol, no backpressure on either side: a byte is transferred in
  // every clock where in_valid (resp. out_valid) is high; the sink must take it.

  state_t          state, state_nx;
  logic [10:0]     byte_cnt;
  logic [7:0]      gap_cnt;
  logic [31:0]     crc, crc_upd;
  logic [3:0][7:0] dline;
  logic            uc_ok, bc_ok, err_flag, sof_seen;

  logic            close_now, accept, uc_hit, bc_hit;
  logic [10:0]     idx_now;
  logic            fwd_fire, sof_fire, eof_fire, good_inc, bad_inc, drop_inc;
  logic [3:0]      status_nx;

  eth_crc32_d8 u_crc (
    .crc_in  (crc),
    .data    (in_data),
    .crc_out (crc_upd)
  );

  // A byte arriving on the closing clock is not part of this frame.
  assign close_now = (state != IDLE) && (gap_cnt == 8'(GAP_CYCLES));
  assign accept    = in_valid && !close_now;
  assign idx_now   = (state == IDLE) ? 11'd0 : byte_cnt;
  assign uc_hit    = (in_data == mac_byte(MAC_ADDR, idx_now[2:0]));
  assign bc_hit    = (in_data == mac_byte(BROADCAST_MAC, idx_now[2:0]));
  assign dbg_state = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = HDR;
      HDR: begin
        if (close_now) begin
          state_nx = IDLE;
        end else if (accept && byte_cnt == 11'd5) begin
          state_nx = ((uc_ok && uc_hit) || (bc_ok && bc_hit)) ? PASS : DROP;
        end
      end
      PASS, DROP: if (close_now) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Byte k leaves the delay line when byte k+4 arrives; forwarding ends with
  // byte MAX_LEN-1, the last byte inside the legal length.
  always_comb begin
    fwd_fire  = accept && (state == PASS) && (idx_now >= 11'd10) &&
                (idx_now <= 11'(MAX_LEN + 3));
    sof_fire  = fwd_fire && (idx_now == 11'd10);
    status_nx = '0;
    status_nx[ST_CRC_ERR]  = (crc != CRC32_RESIDUE);
    status_nx[ST_RUNT]     = (byte_cnt < 11'(MIN_LEN));
    status_nx[ST_TOO_LONG] = (byte_cnt > 11'(MAX_LEN));
    status_nx[ST_CONV_ERR] = err_flag;
    eof_fire  = close_now && (state == PASS) && sof_seen;
    good_inc  = eof_fire && (status_nx == 4'd0);
    bad_inc   = close_now && (state == PASS) && !good_inc;
    drop_inc  = close_now && ((state == HDR) || (state == DROP));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_sof     <= 1'b0;
      out_eof     <= 1'b0;
      out_good    <= 1'b0;
      out_status  <= '0;
      cnt_good    <= '0;
      cnt_bad     <= '0;
      cnt_dropped <= '0;
      byte_cnt    <= '0;
      gap_cnt     <= '0;
      crc         <= CRC32_INIT;
      dline       <= '0;
      uc_ok       <= 1'b0;
      bc_ok       <= 1'b0;
      err_flag    <= 1'b0;
      sof_seen    <= 1'b0;
    end else begin
      out_valid  <= fwd_fire;
      out_sof    <= sof_fire;
      out_eof    <= eof_fire;
      out_good   <= good_inc;
      out_status <= eof_fire ? status_nx : 4'd0;
      if (fwd_fire) out_data <= dline[3];

      if (close_now) begin
        gap_cnt <= '0;
        crc     <= CRC32_INIT;
      end else if (accept) begin
        gap_cnt  <= '0;
        crc      <= crc_upd;
        dline    <= {dline[2:0], in_data};
        if (state == IDLE)            byte_cnt <= 11'd1;
        else if (byte_cnt != 11'h7FF) byte_cnt <= byte_cnt + 11'd1;
      end else if (state != IDLE) begin
        gap_cnt <= gap_cnt + 8'd1;
      end

      if (accept && state == IDLE) begin
        uc_ok    <= uc_hit;
        bc_ok    <= bc_hit;
        err_flag <= in_error;
        sof_seen <= 1'b0;
      end else begin
        if (accept && state == HDR) begin
          uc_ok <= uc_ok && uc_hit;
          bc_ok <= bc_ok && bc_hit;
        end
        if (state != IDLE && in_error) err_flag <= 1'b1;
        if (sof_fire) sof_seen <= 1'b1;
      end

      if (good_inc && cnt_good != 16'hFFFF)    cnt_good    <= cnt_good + 16'd1;
      if (bad_inc && cnt_bad != 16'hFFFF)      cnt_bad     <= cnt_bad + 16'd1;
      if (drop_inc && cnt_dropped != 16'hFFFF) cnt_dropped <= cnt_dropped + 16'd1;
    end
  end

endmodule

// File: tb/tb_eth_rx_frame_filter.sv
// Directed bench for eth_rx_frame_filter: builds frames with a reference
// CRC-32, captures the forwarded stream and checks bytes, status and counters.
module tb_eth_rx_frame_filter;
  import eth_rx_pkg::*;

  localparam logic [47:0] OWN_MAC   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_02;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_error;
  logic [7:0]  out_data;
  logic        out_valid, out_sof, out_eof, out_good;
  logic [3:0]  out_status;
  logic [15:0] cnt_good, cnt_bad, cnt_dropped;
  state_t      dbg_state;

  int total = 0;
  int bad   = 0;

  logic [7:0] frm[$];
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  int         sof_cnt, sof_pos, eof_cnt, collide;
  logic       eof_good;
  logic [3:0] eof_status;

  // clock / reset
  always #20 clock = ~clock;

  eth_rx_frame_filter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_error    (in_error),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_sof     (out_sof),
    .out_eof     (out_eof),
    .out_good    (out_good),
    .out_status  (out_status),
    .cnt_good    (cnt_good),
    .cnt_bad     (cnt_bad),
    .cnt_dropped (cnt_dropped),
    .dbg_state   (dbg_state)
  );

  // output capture, sampled on the falling edge
  initial collide = 0;
  always @(negedge clock) begin
    if (out_valid) begin
      if (out_sof) begin
        sof_cnt++;
        sof_pos = cap_q.size();
      end
      cap_q.push_back(out_data);
    end
    if (out_eof) begin
      eof_cnt++;
      eof_good   = out_good;
      eof_status = out_status;
      if (out_valid) collide++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_ref();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (frm[k]) begin
      c ^= {24'd0, frm[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_frame(input logic [47:0] dest, input int len);
    logic [31:0] fcs;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(dest[47-8*i -: 8]);
    for (int i = 6; i < len - 4; i++) frm.push_back(8'(i * 13 + 5));
    fcs = crc_ref();
    for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
  endtask

  // expected forwarded bytes: index 6 up to the last non-FCS byte, capped at 1517
  task automatic load_exp();
    exp_q.delete();
    for (int k = 6; k <= frm.size() - 5 && k <= 1517; k++) exp_q.push_back(frm[k]);
  endtask

  task automatic clear_cap();
    cap_q.delete();
    sof_cnt    = 0;
    sof_pos    = -1;
    eof_cnt    = 0;
    eof_good   = 1'b0;
    eof_status = 4'd0;
  endtask

  // driver: one byte every second clock, optional 3-clock hole after byte gap_at
  task automatic send_frame(input int gap_at, input int n_bytes);
    for (int i = 0; i < n_bytes; i++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = frm[i];
      @(negedge clock);
      in_valid = 1'b0;
      if (i == gap_at) repeat (2) @(negedge clock);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // scoreboard comparison of one closed frame
  task automatic check_frame(input string tag, input int exp_eof, input logic exp_good,
                             input logic [3:0] exp_status);
    int mism;
    mism = 0;
    check({tag, " count"}, 32'(cap_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < cap_q.size() && k < exp_q.size(); k++)
      if (cap_q[k] !== exp_q[k]) mism++;
    check({tag, " data"}, 32'(mism), 32'd0);
    check({tag, " sof"}, 32'(sof_cnt), (exp_q.size() > 0) ? 32'd1 : 32'd0);
    check({tag, " sof_pos"}, 32'(sof_pos), (exp_q.size() > 0) ? 32'd0 : 32'hFFFF_FFFF);
    check({tag, " eof"}, 32'(eof_cnt), 32'(exp_eof));
    check({tag, " good"}, 32'(eof_good), 32'(exp_good));
    check({tag, " status"}, 32'(eof_status), 32'(exp_status));
  endtask

  task automatic check_cnt(input string tag, input int g, input int b, input int d);
    check({tag, " cnt_good"}, 32'(cnt_good), 32'(g));
    check({tag, " cnt_bad"}, 32'(cnt_bad), 32'(b));
    check({tag, " cnt_dropped"}, 32'(cnt_dropped), 32'(d));
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_error = 1'b0;
    clear_cap();
    idle(3);
    check("reset outs", 32'({out_valid, out_sof, out_eof, out_good, out_status, out_data}), 32'd0);
    check_cnt("reset", 0, 0, 0);
    check("reset state", 32'(dbg_state), 32'(IDLE));
    reset_n = 1'b1;
    idle(2);

    // unicast 64 bytes, valid FCS, with exact eof timing
    build_frame(OWN_MAC, 64);
    load_exp();
    clear_cap();
    send_frame(-1, frm.size());
    idle(4);
    check("t1 eof early", 32'(out_eof), 32'd0);
    idle(1);
    check("t1 eof time", 32'({out_eof, out_good, out_status}), 32'b11_0000);
    idle(4);
    check_frame("t1", 1, 1'b1, 4'b0000);
    check_cnt("t1", 1, 0, 0);

    // broadcast 100 bytes
    build_frame(BROADCAST_MAC, 100);
    load_exp();
    clear_cap();
    send_frame(-1, frm.size());
    idle(10);
    check_frame("t2", 1, 1'b1, 4'b0000);
    check_cnt("t2", 2, 0, 0);

    // foreign unicast: dropped silently
    build_frame(OTHER_MAC, 64);
    exp_q.delete();
    clear_cap();
    send_frame(-1, frm.size());
    idle(10);
    check_frame("t3", 0, 1'b0, 4'b0000);
    check_cnt("t3", 2, 0, 1);

    // corrupted payload byte 20
    build_frame(OWN_MAC, 64);
    frm[20] = frm[20] ^ 8'hFF;
    load_exp();
    clear_cap();
    send_frame(-1, frm.size());
    idle(10);
    check_frame("t4", 1, 1'b0, 4'b0001);
    check_cnt("t4", 2, 1, 1);

    // runt, 40 bytes with good FCS
    build_frame(OWN_MAC, 40);
    load_exp();
    clear_cap();
    send_frame(-1, frm.size());
    idle(10);
    check_frame("t5", 1, 1'b0, 4'b0010);
    check_cnt("t5", 2, 2, 1);

    // oversize, 1600 bytes: forwarding ends with byte 1517
    build_frame(OWN_MAC, 1600);
    load_exp();
    clear_cap();
    send_frame(-1, frm.size());
    idle(10);
    check_frame("t6", 1, 1'b0, 4'b0100);
    check_cnt("t6", 2, 3, 1);

    // converter error one clock after the last byte
    build_frame(OWN_MAC, 64);
    load_exp();
    clear_cap();
    send_frame(-1, frm.size());
    in_error = 1'b1;
    @(negedge clock);
    in_error = 1'b0;
    idle(10);
    check_frame("t7", 1, 1'b0, 4'b1000);
    check_cnt("t7", 2, 4, 1);

    // 3-clock hole mid-frame does not split it
    build_frame(OWN_MAC, 64);
    load_exp();
    clear_cap();
    send_frame(30, frm.size());
    idle(10);
    check_frame("t8", 1, 1'b1, 4'b0000);
    check_cnt("t8", 3, 4, 1);

    // 10-byte frame: byte 6 never leaves the delay line, no eof, counted bad
    build_frame(OWN_MAC, 10);
    load_exp();
    clear_cap();
    send_frame(-1, frm.size());
    idle(10);
    check_frame("t9", 0, 1'b0, 4'b0000);
    check_cnt("t9", 3, 5, 1);

    // frame ending inside the header counts as dropped
    build_frame(OWN_MAC, 64);
    frm = frm[0:2];
    exp_q.delete();
    clear_cap();
    send_frame(-1, frm.size());
    idle(10);
    check_frame("t10", 0, 1'b0, 4'b0000);
    check_cnt("t10", 3, 5, 2);

    // reset pulse at byte 30, then a clean frame
    build_frame(OWN_MAC, 64);
    clear_cap();
    send_frame(-1, 30);
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check_cnt("t11 abort", 0, 0, 0);
    check("t11 state", 32'(dbg_state), 32'(IDLE));
    idle(10);
    check("t11 no eof", 32'(eof_cnt), 32'd0);
    load_exp();
    clear_cap();
    send_frame(-1, frm.size());
    idle(10);
    check_frame("t11", 1, 1'b1, 4'b0000);
    check_cnt("t11", 1, 0, 0);

    check("eof/valid overlap", 32'(collide), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
